// File: rtl/long_divider_axi4s.sv
// long_divider_axi4s: sequential unsigned Q-format divider behind an AXI4-Stream responder.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ing_tvalid/tready/tdata/tlast/tid  operand packet: dividend beat (tlast=0), then divisor beat (tlast=1)
//   egr_tvalid/tready/tdata/tlast/tid  single-beat quotient carrying the dividend beat's ID
//   egr_tuser                        quotient saturated by overflow or divide-by-zero
module long_divider_axi4s #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int Q_BITS_P         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ing_tvalid,
    output logic                        ing_tready,
    input  logic [AXI_DATA_WIDTH_P-1:0] ing_tdata,
    input  logic                        ing_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]   ing_tid,
    output logic                        egr_tvalid,
    input  logic                        egr_tready,
    output logic [AXI_DATA_WIDTH_P-1:0] egr_tdata,
    output logic                        egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]   egr_tid,
    output logic                        egr_tuser
);
    localparam int W  = AXI_DATA_WIDTH_P;
    localparam int NW = W + Q_BITS_P;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {RX_DIVIDEND_E, RX_DIVISOR_E, DIVIDE_E, TX_QUOTIENT_E} state_t;

    state_t        state;
    logic [NW-1:0] num;
    logic [W-1:0]  rem;
    logic [W-1:0]  divisor;
    logic [CW-1:0] cnt;
    logic [W:0]    trial;
    logic          fits;
    logic [NW-1:0] quot;
    logic [W-1:0]  rem_next;
    logic          ovf;
    logic          hs_in;

    // num shifts the numerator out MSB first while quotient bits shift in at the LSB,
    // so after NW iterations it holds the full quotient.
    always_comb begin
        hs_in    = ing_tvalid & ing_tready;
        trial    = {rem, num[NW-1]};
        fits     = trial >= {1'b0, divisor};
        quot     = {num[NW-2:0], fits};
        rem_next = fits ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
        ovf      = |(quot >> W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_DIVIDEND_E;
            ing_tready <= 1'b0;
            egr_tvalid <= 1'b0;
            egr_tdata  <= '0;
            egr_tlast  <= 1'b0;
            egr_tid    <= '0;
            egr_tuser  <= 1'b0;
            num        <= '0;
            rem        <= '0;
            divisor    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                RX_DIVIDEND_E: begin
                    ing_tready <= 1'b1;
                    if (hs_in && !ing_tlast) begin
                        num     <= NW'(ing_tdata) << Q_BITS_P;
                        egr_tid <= ing_tid;
                        state   <= RX_DIVISOR_E;
                    end
                end
                RX_DIVISOR_E: begin
                    if (hs_in && ing_tlast) begin
                        divisor    <= ing_tdata;
                        rem        <= '0;
                        cnt        <= '0;
                        ing_tready <= 1'b0;
                        if (ing_tdata == '0) begin
                            egr_tdata <= '1;
                            egr_tuser <= 1'b1;
                            state     <= TX_QUOTIENT_E;
                        end else begin
                            state <= DIVIDE_E;
                        end
                    end else if (hs_in) begin
                        num     <= NW'(ing_tdata) << Q_BITS_P;
                        egr_tid <= ing_tid;
                    end
                end
                DIVIDE_E: begin
                    num <= quot;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NW - 1)) begin
                        egr_tdata <= ovf ? '1 : quot[W-1:0];
                        egr_tuser <= ovf;
                        state     <= TX_QUOTIENT_E;
                    end
                end
                TX_QUOTIENT_E: begin
                    // Result is registered on entry; valid follows one edge later.
                    if (!egr_tvalid) begin
                        egr_tvalid <= 1'b1;
                        egr_tlast  <= 1'b1;
                    end else if (egr_tready) begin
                        egr_tvalid <= 1'b0;
                        egr_tlast  <= 1'b0;
                        ing_tready <= 1'b1;
                        state      <= RX_DIVIDEND_E;
                    end
                end
                default: state <= RX_DIVIDEND_E;
            endcase
        end
    end
endmodule

// File: tb/tb_long_divider_axi4s.sv
// tb_long_divider_axi4s: randomized and directed checks of long_divider_axi4s against an arithmetic model.
module tb_long_divider_axi4s;
    logic        clk;
    logic        rst_n;
    logic        ing_tvalid;
    logic        ing_tready;
    logic [31:0] ing_tdata;
    logic        ing_tlast;
    logic [3:0]  ing_tid;
    logic        egr_tvalid;
    logic        egr_tready;
    logic [31:0] egr_tdata;
    logic        egr_tlast;
    logic [3:0]  egr_tid;
    logic        egr_tuser;

    long_divider_axi4s dut (
        .clk(clk), .rst_n(rst_n),
        .ing_tvalid(ing_tvalid), .ing_tready(ing_tready), .ing_tdata(ing_tdata),
        .ing_tlast(ing_tlast), .ing_tid(ing_tid),
        .egr_tvalid(egr_tvalid), .egr_tready(egr_tready), .egr_tdata(egr_tdata),
        .egr_tlast(egr_tlast), .egr_tid(egr_tid), .egr_tuser(egr_tuser)
    );

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic [3:0]  id;
        int          t0;
        int          e;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats = 0;
    logic        bp_hold = 0;
    logic        rand_rdy = 0;
    logic        have = 0;
    logic [31:0] md = 0;
    logic [3:0]  mid = 0;
    logic        prev_v = 0;
    logic [31:0] last_d = 0;
    logic        last_u = 0;
    logic [3:0]  last_id = 0;
    int          last_lat = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        egr_tready = 1;
        forever begin
            @(posedge clk);
            #2;
            egr_tready = bp_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Quotient from plain arithmetic: (a * 2^8) / b, saturated when it does not fit 32 bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] id, input int t);
        exp_t        r;
        logic [63:0] n;
        logic [63:0] qq;
        n    = {24'd0, a, 8'd0};
        r.id = id;
        r.t0 = t;
        if (b == 0) begin
            r.d = 32'hFFFF_FFFF;
            r.u = 1;
            r.e = t + 1;
        end else begin
            qq  = n / {32'd0, b};
            r.u = qq[63:32] != 0;
            r.d = r.u ? 32'hFFFF_FFFF : qq[31:0];
            r.e = t + 41;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] id);
        int n = 0;
        ing_tdata  = d;
        ing_tlast  = l;
        ing_tid    = id;
        ing_tvalid = 1;
        while (!ing_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ing_tready) begin
            chk("ing_handshake_timeout", {63'd0, ing_tready}, 64'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            if (!l) begin
                md   = d;
                mid  = id;
                have = 1;
            end else if (have) begin
                q.push_back(model(md, d, mid, cyc));
                have = 0;
            end
        end
        ing_tvalid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || egr_tvalid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, (q.size() != 0 || egr_tvalid)}, 64'd0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (egr_tvalid) begin
                chk("ing_tready_low_while_valid", {63'd0, ing_tready}, 64'd0);
                chk("beat_expected", {63'd0, q.size() != 0}, 64'd1);
                if (q.size() != 0) begin
                    chk("egr_tdata", {32'd0, egr_tdata}, {32'd0, q[0].d});
                    chk("egr_tuser", {63'd0, egr_tuser}, {63'd0, q[0].u});
                    chk("egr_tid", {60'd0, egr_tid}, {60'd0, q[0].id});
                    chk("egr_tlast", {63'd0, egr_tlast}, 64'd1);
                    if (!prev_v) begin
                        chk("egr_latency", 64'(cyc), 64'(q[0].e));
                        last_lat = cyc - q[0].t0;
                    end
                    if (egr_tready) begin
                        last_d  = egr_tdata;
                        last_u  = egr_tuser;
                        last_id = egr_tid;
                        beats++;
                        void'(q.pop_front());
                    end
                end
            end
            prev_v = egr_tvalid;
        end
    end

    initial begin
        int bb;
        int n;
        logic [31:0] a;
        logic [31:0] b;
        ing_tvalid = 0;
        ing_tdata  = 0;
        ing_tlast  = 0;
        ing_tid    = 0;
        rst_n      = 1;
        #1 rst_n = 0;
        gap(3);
        chk("rst_ing_tready", {63'd0, ing_tready}, 64'd0);
        chk("rst_egr_tvalid", {63'd0, egr_tvalid}, 64'd0);
        chk("rst_egr_tdata", {32'd0, egr_tdata}, 64'd0);
        chk("rst_egr_tlast", {63'd0, egr_tlast}, 64'd0);
        chk("rst_egr_tid", {60'd0, egr_tid}, 64'd0);
        chk("rst_egr_tuser", {63'd0, egr_tuser}, 64'd0);
        rst_n = 1;
        #1 chk("ing_tready_before_first_edge", {63'd0, ing_tready}, 64'd0);
        gap(1);
        chk("ing_tready_first_edge", {63'd0, ing_tready}, 64'd1);

        send(32'd256000, 0, 4'h5);
        send(32'd112640, 1, 4'h0);
        wait_done();
        chk("nominal_data", {32'd0, last_d}, 64'd581);
        chk("nominal_user", {63'd0, last_u}, 64'd0);
        chk("nominal_id", {60'd0, last_id}, 64'h5);
        chk("nominal_latency", 64'(last_lat), 64'd41);

        send(32'h100, 0, 4'h3);
        send(32'h0, 1, 4'h7);
        wait_done();
        chk("div0_data", {32'd0, last_d}, 64'hFFFF_FFFF);
        chk("div0_user", {63'd0, last_u}, 64'd1);
        chk("div0_id", {60'd0, last_id}, 64'h3);
        chk("div0_latency", 64'(last_lat), 64'd1);

        send(32'hFFFF_FFFF, 0, 4'h9);
        send(32'h1, 1, 4'h9);
        wait_done();
        chk("ovf_data", {32'd0, last_d}, 64'hFFFF_FFFF);
        chk("ovf_user", {63'd0, last_u}, 64'd1);

        bp_hold = 1;
        send(32'h12_3400, 0, 4'hA);
        send(32'h300, 1, 4'h1);
        n = 0;
        while (!egr_tvalid && n < 100) begin
            gap(1);
            n++;
        end
        chk("bp_valid_seen", {63'd0, egr_tvalid}, 64'd1);
        bb = beats;
        gap(10);
        chk("bp_no_beat_while_held", 64'(beats), 64'(bb));
        chk("bp_ing_tready", {63'd0, ing_tready}, 64'd0);
        bp_hold = 0;
        wait_done();
        chk("bp_single_beat", 64'(beats), 64'(bb + 1));
        chk("bp_data", {32'd0, last_d}, 64'h6_1155);
        chk("bp_id", {60'd0, last_id}, 64'hA);

        send(32'hDEAD, 1, 4'h4);
        send(32'h500, 0, 4'h1);
        gap(3);
        send(32'h800, 0, 4'h2);
        gap(5);
        send(32'h100, 1, 4'h3);
        wait_done();
        chk("resync_data", {32'd0, last_d}, 64'h800);
        chk("resync_id", {60'd0, last_id}, 64'h2);

        rand_rdy = 1;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 9) == 0) send($urandom, 1, 4'($urandom));
            a = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = a >> $urandom_range(0, 20);
                default: b = $urandom_range(0, 1) ? 32'd0 : $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) send($urandom, 0, 4'($urandom));
            send(a, 0, 4'($urandom));
            gap($urandom_range(0, 3));
            send(b, 1, 4'($urandom));
            gap($urandom_range(0, 2));
        end
        wait_done();
        rand_rdy = 0;

        send(32'h1000, 0, 4'h4);
        send(32'h10, 1, 4'h0);
        bb = beats;
        gap(20);
        rst_n = 0;
        q.delete();
        have = 0;
        #1;
        chk("midrst_ing_tready", {63'd0, ing_tready}, 64'd0);
        chk("midrst_egr_tvalid", {63'd0, egr_tvalid}, 64'd0);
        chk("midrst_egr_tdata", {32'd0, egr_tdata}, 64'd0);
        chk("midrst_egr_tlast", {63'd0, egr_tlast}, 64'd0);
        chk("midrst_egr_tid", {60'd0, egr_tid}, 64'd0);
        chk("midrst_egr_tuser", {63'd0, egr_tuser}, 64'd0);
        gap(2);
        rst_n = 1;
        gap(50);
        chk("midrst_no_beat", 64'(beats), 64'(bb));
        send(32'h300, 0, 4'h6);
        send(32'h100, 1, 4'h0);
        wait_done();
        chk("after_rst_data", {32'd0, last_d}, 64'h300);
        chk("after_rst_id", {60'd0, last_id}, 64'h6);
        chk("after_rst_beats", 64'(beats), 64'(bb + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
